// File: rtl/axi_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_pkg: shared AXI3 write-responder types and constants         |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package axi_pkg;

  localparam int ID_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_COLLECT = 3'b001,
    ST_WRITE   = 3'b010,
    ST_RESP    = 3'b100
  } state_t;

  // Address is misaligned when any byte-offset bit below the beat size is set.
  function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] size);
    case (size)
      3'd1:    return addr_lo[0];
      3'd2:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_wr_resp_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_wr_resp_mem: DEPTH x 32 byte-strobed RAM, async debug read   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_wr_resp_mem #(
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [31:0]              dbg_rdata
);

  logic [31:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (wstrb[k]) r_mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign dbg_rdata = r_mem[dbg_addr];

endmodule
`default_nettype wire

// File: rtl/axi_wr_resp_slave.sv
`default_nettype none
// +------------------------------------------------------------------+
// | axi_wr_resp_slave: single-beat AXI3 write responder with memory  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module axi_wr_resp_slave
  import axi_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000,
  parameter int          AW_DELAY  = 0,
  parameter int          W_DELAY   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ID_W-1:0]          awid,
  input  logic [31:0]              awaddr,
  input  logic [7:0]               awlen,
  input  logic [2:0]               awsize,
  input  logic [1:0]               awburst,
  input  logic [1:0]               awlock,
  input  logic [3:0]               awcache,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [ID_W-1:0]          wid,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  input  logic                     wlast,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [ID_W-1:0]          bid,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DATA_W-1:0]        dbg_rdata
);

  localparam int          IDX_W      = $clog2(DEPTH);
  localparam logic [31:0] C_SPAN     = 32'(DEPTH) * 32'd4;
  localparam logic [3:0]  C_AW_DELAY = 4'(AW_DELAY);
  localparam logic [3:0]  C_W_DELAY  = 4'(W_DELAY);

  state_t              r_state, w_state_nx;
  logic                r_aw_got, r_w_got;
  logic [3:0]          r_cnt;
  logic [ID_W-1:0]     r_awid, r_wid;
  logic [31:0]         r_awaddr;
  logic [7:0]          r_awlen;
  logic [2:0]          r_awsize;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_wlast;
  logic                w_aw_fire, w_w_fire;
  logic [31:0]         w_offset;
  logic                w_err, w_mem_we;
  logic                w_unused;

  assign w_unused = ^{awburst, awlock, awcache, awprot};

  always_comb begin
    w_state_nx = r_state;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    w_aw_fire  = 1'b0;
    w_w_fire   = 1'b0;
    case (r_state)
      ST_COLLECT: begin
        // Ready is held low while reset is asserted since the state itself sits in COLLECT.
        awready   = !reset && !r_aw_got && (r_cnt >= C_AW_DELAY);
        wready    = !reset && !r_w_got && (r_cnt >= C_W_DELAY);
        w_aw_fire = awvalid && awready;
        w_w_fire  = wvalid && wready;
        if ((r_aw_got || w_aw_fire) && (r_w_got || w_w_fire)) w_state_nx = ST_WRITE;
      end
      ST_WRITE: w_state_nx = ST_RESP;
      ST_RESP: begin
        bvalid = 1'b1;
        if (bready) w_state_nx = ST_COLLECT;
      end
      default: w_state_nx = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_COLLECT;
    else       r_state <= w_state_nx;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_aw_got <= 1'b0;
      r_w_got  <= 1'b0;
      r_cnt    <= 4'd0;
      r_awid   <= '0;
      r_awaddr <= '0;
      r_awlen  <= '0;
      r_awsize <= '0;
      r_wid    <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_wlast  <= 1'b0;
      bid      <= '0;
      bresp    <= BRESP_OKAY;
    end else begin
      case (r_state)
        ST_COLLECT: begin
          if (r_cnt != 4'hf) r_cnt <= r_cnt + 4'd1;
          if (w_aw_fire) begin
            r_awid   <= awid;
            r_awaddr <= awaddr;
            r_awlen  <= awlen;
            r_awsize <= awsize;
            r_aw_got <= 1'b1;
          end
          if (w_w_fire) begin
            r_wid   <= wid;
            r_wdata <= wdata;
            r_wstrb <= wstrb;
            r_wlast <= wlast;
            r_w_got <= 1'b1;
          end
        end
        ST_WRITE: begin
          bid   <= r_awid;
          bresp <= w_err ? BRESP_SLVERR : BRESP_OKAY;
        end
        ST_RESP: begin
          if (bready) begin
            r_aw_got <= 1'b0;
            r_w_got  <= 1'b0;
            r_cnt    <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // The subtraction may wrap below BASE_ADDR; the explicit lower-bound check covers that case.
  assign w_offset = r_awaddr - BASE_ADDR;
  assign w_err    = (r_awlen != 8'd0) | (r_awsize > 3'd2) | !r_wlast | (r_wid != r_awid) |
                    (r_awaddr < BASE_ADDR) | (w_offset >= C_SPAN) |
                    misaligned(r_awaddr[1:0], r_awsize);
  assign w_mem_we = (r_state == ST_WRITE) && !w_err;

  axi_wr_resp_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk      (clk),
    .we       (w_mem_we),
    .waddr    (w_offset[2 +: IDX_W]),
    .wdata    (r_wdata),
    .wstrb    (r_wstrb),
    .dbg_addr (dbg_addr),
    .dbg_rdata(dbg_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_axi_wr_resp_slave.sv
`default_nettype none
// Bench for axi_wr_resp_slave: table vectors, multi-cycle corner sequences and random
// writes scored against a behavioural memory/response model.
module tb_axi_wr_resp_slave;
  import axi_pkg::*;

  localparam int          DEPTH  = 256;
  localparam logic [31:0] BASE   = 32'h1c00_0000;
  localparam int          BUDGET = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  awid = '0, wid = '0;
  logic [31:0] awaddr = '0, wdata = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = 3'd2;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1;
  logic        d_awvalid = 1'b0, d_wvalid = 1'b0, d_bready = 1'b1;
  logic [7:0]  dbg_addr = '0;
  logic        awready, wready, bvalid, d_awready, d_wready, d_bvalid;
  logic [3:0]  bid, d_bid;
  logic [1:0]  bresp, d_bresp;
  logic [31:0] dbg_rdata, d_dbg_rdata;

  int checks = 0;
  int errors = 0;
  int aw_first = -1;
  int w_first = -1;

  logic [31:0] model_mem [DEPTH];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [3:0]  wid;
    logic        last;
    logic [3:0]  strb;
    logic [31:0] data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[10];

  always #5 clk = ~clk;

  axi_wr_resp_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .AW_DELAY(0), .W_DELAY(0)) dut (
    .clk(clk), .reset(reset), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(2'b01), .awlock(2'b00), .awcache(4'h0), .awprot(3'h0),
    .awvalid(awvalid), .awready(awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(wvalid), .wready(wready), .bid(bid), .bresp(bresp),
    .bvalid(bvalid), .bready(bready), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata));

  axi_wr_resp_slave #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .AW_DELAY(3), .W_DELAY(5)) dut_d (
    .clk(clk), .reset(reset), .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(2'b01), .awlock(2'b00), .awcache(4'h0), .awprot(3'h0),
    .awvalid(d_awvalid), .awready(d_awready), .wid(wid), .wdata(wdata), .wstrb(wstrb),
    .wlast(wlast), .wvalid(d_wvalid), .wready(d_wready), .bid(d_bid), .bresp(d_bresp),
    .bvalid(d_bvalid), .bready(d_bready), .dbg_addr(dbg_addr), .dbg_rdata(d_dbg_rdata));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Response rule written directly from the acceptance criteria.
  function automatic logic [1:0] model_resp(input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [3:0] wid_i, input logic last);
    longint off;
    bit bad;
    off = longint'(addr) - longint'(BASE);
    bad = (len != 0) || (size > 2) || !last || (wid_i != id) || (off < 0) ||
          (off >= DEPTH * 4) || ((addr % (32'd1 << size)) != 0);
    return bad ? 2'b10 : 2'b00;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int idx;
    idx = int'((addr - BASE) / 4);
    for (int k = 0; k < 4; k++)
      if (strb[k]) model_mem[idx][8*k +: 8] = data[8*k +: 8];
  endtask

  task automatic check_mem(input string name, input int idx);
    dbg_addr = 8'(idx);
    #1;
    check(name, dbg_rdata, model_mem[idx]);
  endtask

  // Starts and ends on a falling edge; handshakes happen on the following rising edge.
  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
      input logic [2:0] size, input logic [3:0] wid_i, input logic [31:0] data,
      input logic [3:0] strb, input logic last, input int ag, input int wg,
      output logic [1:0] resp, output logic [3:0] rid, output bit ok);
    ok = 1'b1;
    fork
      begin
        repeat (ag) @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awvalid = 1'b1;
        for (int t = 0; t < BUDGET && !awready; t++) @(negedge clk);
        if (!awready) ok = 1'b0;
        @(negedge clk);
        awvalid = 1'b0;
      end
      begin
        repeat (wg) @(negedge clk);
        wid = wid_i; wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        for (int t = 0; t < BUDGET && !wready; t++) @(negedge clk);
        if (!wready) ok = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
      end
    join
    for (int t = 0; t < BUDGET && !bvalid; t++) @(negedge clk);
    if (!bvalid) ok = 1'b0;
    resp = bresp;
    rid  = bid;
    @(negedge clk);
  endtask

  task automatic run_txn(input string name, input logic [3:0] id, input logic [31:0] addr,
      input logic [7:0] len, input logic [2:0] size, input logic [3:0] wid_i,
      input logic [31:0] data, input logic [3:0] strb, input logic last,
      input int ag, input int wg, input logic [1:0] exp);
    logic [1:0] r;
    logic [3:0] b;
    bit ok;
    do_write(id, addr, len, size, wid_i, data, strb, last, ag, wg, r, b, ok);
    check({name, "_handshake"}, 32'(ok), 32'd1);
    check({name, "_bresp"}, 32'(r), 32'(exp));
    check({name, "_bid"}, 32'(b), 32'(id));
    if (exp == BRESP_OKAY) model_write(addr, data, strb);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [7:0]  l;
    logic [2:0]  s;
    logic [3:0]  id, wi;
    logic        lst;
    int          idx, base_w;

    vecs[0] = '{4'h1, BASE + 32'h400, 8'd0, 3'd2, 4'h1, 1'b1, 4'hf, 32'h1111_1111, 2'b10};
    vecs[1] = '{4'h2, BASE + 32'h8,   8'd1, 3'd2, 4'h2, 1'b1, 4'hf, 32'h2222_2222, 2'b10};
    vecs[2] = '{4'h3, BASE + 32'h8,   8'd0, 3'd2, 4'h4, 1'b1, 4'hf, 32'h3333_3333, 2'b10};
    vecs[3] = '{4'h4, BASE - 32'h4,   8'd0, 3'd2, 4'h4, 1'b1, 4'hf, 32'h4444_4444, 2'b10};
    vecs[4] = '{4'h5, BASE + 32'h9,   8'd0, 3'd2, 4'h5, 1'b1, 4'hf, 32'h5555_5555, 2'b10};
    vecs[5] = '{4'h6, BASE + 32'ha,   8'd0, 3'd1, 4'h6, 1'b1, 4'hc, 32'h6666_6666, 2'b00};
    vecs[6] = '{4'h7, BASE + 32'h3fc, 8'd0, 3'd2, 4'h7, 1'b1, 4'hf, 32'h7777_7777, 2'b00};
    vecs[7] = '{4'h8, BASE + 32'hc,   8'd0, 3'd3, 4'h8, 1'b1, 4'hf, 32'h8888_8888, 2'b10};
    vecs[8] = '{4'h9, BASE + 32'hc,   8'd0, 3'd2, 4'h9, 1'b0, 4'hf, 32'h9999_9999, 2'b10};
    vecs[9] = '{4'ha, BASE + 32'h7,   8'd0, 3'd0, 4'ha, 1'b1, 4'h8, 32'haaaa_aaaa, 2'b00};

    // Reset state of both instances
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(awready), 0);
    check("rst_wready", 32'(wready), 0);
    check("rst_bvalid", 32'(bvalid), 0);
    check("rst_bid", 32'(bid), 0);
    check("rst_bresp", 32'(bresp), 0);
    check("rst_d_awready", 32'(d_awready), 0);
    check("rst_d_bvalid", 32'(d_bvalid), 0);

    // Delayed readiness and a stalled B channel
    awid = 4'h9; awaddr = BASE + 32'h20; awlen = 8'd0; awsize = 3'd2; wid = 4'h9;
    wdata = 32'hcafe_f00d; wstrb = 4'hf; wlast = 1'b1;
    d_awvalid = 1'b1; d_wvalid = 1'b1; d_bready = 1'b0;
    reset = 1'b0;
    #1;
    for (int k = 0; k < 12 && (d_awvalid || d_wvalid); k++) begin
      bit af, wf;
      af = d_awvalid && d_awready;
      wf = d_wvalid && d_wready;
      if (af && aw_first < 0) aw_first = k;
      if (wf && w_first < 0) w_first = k;
      @(negedge clk); #1;
      if (af) d_awvalid = 1'b0;
      if (wf) d_wvalid = 1'b0;
    end
    check("dly_awready_first_cnt", 32'(aw_first), 32'd3);
    check("dly_wready_first_cnt", 32'(w_first), 32'd5);
    check("dly_bvalid_in_write", 32'(d_bvalid), 0);
    @(negedge clk); #1;
    d_awvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("stall_bvalid", 32'(d_bvalid), 1);
      check("stall_bid", 32'(d_bid), 32'h9);
      check("stall_bresp", 32'(d_bresp), 0);
      check("stall_awready", 32'(d_awready), 0);
      @(negedge clk); #1;
    end
    d_bready = 1'b1;
    check("stall_release_bvalid", 32'(d_bvalid), 1);
    @(negedge clk); #1;
    check("post_b_bvalid", 32'(d_bvalid), 0);
    check("post_b_awready_cnt0", 32'(d_awready), 0);
    d_awvalid = 1'b0;
    dbg_addr = 8'd8; #1;
    check("dly_readback", d_dbg_rdata, 32'hcafe_f00d);
    @(negedge clk);

    // Give every word a known value so later readbacks are meaningful
    for (int i = 0; i < DEPTH; i++)
      run_txn("init", 4'(i), BASE + 32'(4 * i), 8'd0, 3'd2, 4'(i), $urandom, 4'hf, 1'b1, 0, 0, 2'b00);

    // AW and W in the same cycle: latency and ready re-assertion
    awid = 4'h5; awaddr = BASE + 32'h10; awlen = 8'd0; awsize = 3'd2;
    wid = 4'h5; wdata = 32'hdead_beef; wstrb = 4'hf; wlast = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1;
    check("t1_awready", 32'(awready), 1);
    check("t1_wready", 32'(wready), 1);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("t1_bvalid_n1", 32'(bvalid), 0);
    check("t1_awready_n1", 32'(awready), 0);
    @(negedge clk);
    check("t1_bvalid_n2", 32'(bvalid), 1);
    check("t1_bresp", 32'(bresp), 0);
    check("t1_bid", 32'(bid), 32'h5);
    @(negedge clk);
    check("t1_bvalid_n3", 32'(bvalid), 0);
    check("t1_awready_n3", 32'(awready), 1);
    check("t1_wready_n3", 32'(wready), 1);
    model_write(BASE + 32'h10, 32'hdead_beef, 4'hf);
    dbg_addr = 8'd4; #1;
    check("t1_readback", dbg_rdata, 32'hdead_beef);
    @(negedge clk);

    // W three cycles ahead of AW with a partial strobe
    run_txn("t2_prep", 4'h2, BASE, 8'd0, 3'd2, 4'h2, 32'hffff_ffff, 4'hf, 1'b1, 0, 0, 2'b00);
    wid = 4'h2; wdata = 32'h1234_5678; wstrb = 4'b0011; wlast = 1'b1; wvalid = 1'b1;
    check("t2_wready", 32'(wready), 1);
    @(negedge clk);
    wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("t2_wready_held", 32'(wready), 0);
      check("t2_awready_open", 32'(awready), 1);
      @(negedge clk);
    end
    awid = 4'h2; awaddr = BASE; awlen = 8'd0; awsize = 3'd2; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    check("t2_bvalid_early", 32'(bvalid), 0);
    @(negedge clk);
    check("t2_bvalid", 32'(bvalid), 1);
    check("t2_bresp", 32'(bresp), 0);
    @(negedge clk);
    dbg_addr = 8'd0; #1;
    check("t2_readback", dbg_rdata, 32'hffff_5678);
    model_mem[0] = 32'hffff_5678;
    @(negedge clk);

    // Table vectors: error classes and legal narrow/edge writes
    for (int i = 0; i < 10; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].id, vecs[i].addr, vecs[i].len, vecs[i].size,
              vecs[i].wid, vecs[i].data, vecs[i].strb, vecs[i].last, i % 3, (i + 1) % 3,
              vecs[i].exp_resp);
      check_mem($sformatf("vec%0d_mem", i), int'(((vecs[i].addr - BASE) >> 2) & 32'hff));
      @(negedge clk);
    end

    // Reset while the response is pending
    bready = 1'b0;
    run_txn("t5_pending", 4'hb, BASE + 32'h40, 8'd0, 3'd2, 4'hb, 32'h0bad_f00d, 4'hf, 1'b1, 0, 0, 2'b00);
    check("t5_bvalid_held", 32'(bvalid), 1);
    #2 reset = 1'b1;
    #1;
    check("t5_bvalid_async", 32'(bvalid), 0);
    check("t5_bid_reset", 32'(bid), 0);
    check("t5_awready_in_reset", 32'(awready), 0);
    @(negedge clk);
    reset = 1'b0;
    bready = 1'b1;
    @(negedge clk);
    check("t5_bvalid_after", 32'(bvalid), 0);
    run_txn("t5_next", 4'hc, BASE + 32'h44, 8'd0, 3'd2, 4'hc, 32'h5a5a_a5a5, 4'hf, 1'b1, 0, 0, 2'b00);
    check_mem("t5_mem40", 16);
    check_mem("t5_mem44", 17);
    @(negedge clk);

    // Eight writes to consecutive words with random channel gaps
    base_w = $urandom_range(0, DEPTH - 8);
    for (int i = 0; i < 8; i++)
      run_txn("t6", 4'(i + 3), BASE + 32'(4 * (base_w + i)), 8'd0, 3'd2, 4'(i + 3), $urandom,
              4'($urandom), 1'b1, $urandom_range(0, 3), $urandom_range(0, 3), 2'b00);
    for (int i = 0; i < 8; i++) check_mem("t6_mem", base_w + i);
    @(negedge clk);

    // Random mix of legal and illegal writes
    for (int i = 0; i < 60; i++) begin
      id = 4'($urandom); wi = id; l = 8'd0; lst = 1'b1;
      s = 3'($urandom_range(0, 2));
      idx = $urandom_range(0, DEPTH - 1);
      a = BASE + 32'(4 * idx);
      if (s == 3'd0) a = a + 32'($urandom_range(0, 3));
      else if (s == 3'd1) a = a + 32'(2 * $urandom_range(0, 1));
      case ($urandom_range(0, 9))
        6: a = BASE - 32'(4 * $urandom_range(1, 100));
        7: a = BASE + 32'h400 + 32'(4 * $urandom_range(0, 100));
        8: begin s = 3'd2; a = BASE + 32'(4 * idx) + 32'($urandom_range(1, 3)); end
        9: begin
          case ($urandom_range(0, 3))
            0: l = 8'($urandom_range(1, 255));
            1: wi = id ^ 4'($urandom_range(1, 15));
            2: lst = 1'b0;
            default: s = 3'($urandom_range(3, 7));
          endcase
        end
        default: ;
      endcase
      d = $urandom;
      run_txn("rand", id, a, l, s, wi, d, 4'($urandom), lst, $urandom_range(0, 2),
              $urandom_range(0, 2), model_resp(id, a, l, s, wi, lst));
    end

    for (int i = 0; i < DEPTH; i++) check_mem("final_mem", i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
